// File: rtl/ram_tap_line_delay.sv
// Cascaded RAM-based tapped delay line: NTAPS circular buffers sharing one write pointer.
// Optional fill tracking and primed flag enabled by defining RAM_TAP_PRIMED_EN.
module ram_tap_line_delay #(
   parameter int DSIZE         = 8,
   parameter int MAX_DEPTH     = 16,
   parameter int NTAPS         = 3,
   parameter int DEFAULT_DEPTH = MAX_DEPTH,
   localparam int ASIZE        = $clog2(MAX_DEPTH + 1)
) (
   input  logic                     clk,
   input  logic                     Reset,
   input  logic [DSIZE-1:0]         Din,
   input  logic                     din_valid,
   input  logic [ASIZE-1:0]         depth,
   input  logic                     depth_load,
   output logic [NTAPS*DSIZE-1:0]   Q,
   output logic                     q_valid,
   output logic                     primed
);

   localparam int PW    = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;
   localparam int DEF_D = (DEFAULT_DEPTH < 1) ? 1 :
                          (DEFAULT_DEPTH > MAX_DEPTH) ? MAX_DEPTH : DEFAULT_DEPTH;

   function automatic logic [ASIZE-1:0] clamp_depth(input logic [ASIZE-1:0] d);
      logic [ASIZE-1:0] r;
      r = d;
      if (d == '0)
         r = ASIZE'(1);
      else if (d > ASIZE'(MAX_DEPTH))
         r = ASIZE'(MAX_DEPTH);
      return r;
   endfunction

   logic [ASIZE-1:0]       depth_q, depth_d;
   logic [PW-1:0]          ptr_q, ptr_d;
   logic [NTAPS*DSIZE-1:0] q_q, q_d;
   logic                   q_valid_q, q_valid_d;
   logic                   accept;
   logic                   ptr_wrap;
   logic [DSIZE-1:0]       tap_in  [NTAPS];
   logic [DSIZE-1:0]       tap_out [NTAPS];

`ifdef RAM_TAP_PRIMED_EN
   localparam int FW = $clog2(NTAPS * MAX_DEPTH + 2);
   logic [FW-1:0] fill_q, fill_d;
   logic [FW-1:0] fill_tgt;
   logic          primed_q, primed_d;

   // Field NTAPS-1 becomes real one accept after the whole cascade has filled.
   assign fill_tgt = FW'(NTAPS) * FW'(depth_q) + FW'(1);
`endif

   assign accept   = din_valid & ~depth_load & ~Reset;
   assign ptr_wrap = (ASIZE'(ptr_q) == (depth_q - ASIZE'(1)));

   // Each tap reads the word about to be overwritten, so tap k+1 is fed the
   // sample leaving tap k in the same cycle.
   for (genvar k = 0; k < NTAPS; k++) begin : g_tap
      logic [DSIZE-1:0] mem [MAX_DEPTH];

      if (k == 0) begin : g_first
         assign tap_in[k] = Din;
      end else begin : g_next
         assign tap_in[k] = tap_out[k-1];
      end

      assign tap_out[k] = mem[ptr_q];

      always_ff @(posedge clk) begin
         if (accept)
            mem[ptr_q] <= tap_in[k];
      end
   end

   always_comb begin
      depth_d   = depth_q;
      ptr_d     = ptr_q;
      q_d       = q_q;
      q_valid_d = 1'b0;
`ifdef RAM_TAP_PRIMED_EN
      fill_d    = fill_q;
      primed_d  = primed_q;
`endif
      if (depth_load) begin
         depth_d  = clamp_depth(depth);
         ptr_d    = '0;
`ifdef RAM_TAP_PRIMED_EN
         fill_d   = '0;
         primed_d = 1'b0;
`endif
      end else if (din_valid) begin
         ptr_d = ptr_wrap ? '0 : ptr_q + PW'(1);
         for (int k = 0; k < NTAPS; k++)
            q_d[k*DSIZE +: DSIZE] = tap_out[k];
`ifdef RAM_TAP_PRIMED_EN
         if (fill_q != fill_tgt)
            fill_d = fill_q + FW'(1);
         primed_d  = (fill_d == fill_tgt);
         q_valid_d = primed_d;
`else
         q_valid_d = 1'b1;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (Reset) begin
         depth_q   <= ASIZE'(DEF_D);
         ptr_q     <= '0;
         q_q       <= '0;
         q_valid_q <= 1'b0;
`ifdef RAM_TAP_PRIMED_EN
         fill_q    <= '0;
         primed_q  <= 1'b0;
`endif
      end else begin
         depth_q   <= depth_d;
         ptr_q     <= ptr_d;
         q_q       <= q_d;
         q_valid_q <= q_valid_d;
`ifdef RAM_TAP_PRIMED_EN
         fill_q    <= fill_d;
         primed_q  <= primed_d;
`endif
      end
   end

   assign Q       = q_q;
   assign q_valid = q_valid_q;
`ifdef RAM_TAP_PRIMED_EN
   assign primed  = primed_q;
`else
   assign primed  = 1'b0;
`endif

endmodule

// File: doc/ram_tap_line_delay.md
RAM_TAP_LINE_DELAY -- requirements
Module: ram_tap_line_delay

Interface
REQ-001 Parameter DSIZE, default 8: sample width in bits.
REQ-002 Parameter MAX_DEPTH, default 16: largest per-tap delay in samples, and the RAM words per tap.
REQ-003 Parameter NTAPS, default 3: number of cascaded delay taps.
REQ-004 Parameter DEFAULT_DEPTH, default MAX_DEPTH: per-tap delay after reset.
REQ-005 Derived ASIZE = $clog2(MAX_DEPTH+1).
REQ-006 Clocking: one clock; reset is synchronous and active-high.
REQ-007 Port clk, input, 1: sole clock, rising edge.
REQ-008 Port Reset, input, 1: synchronous active-high reset.
REQ-009 Port Din, input, DSIZE: input sample.
REQ-010 Port din_valid, input, 1: Din accepted at this edge.
REQ-011 Port depth, input, ASIZE: requested per-tap delay; sampled only on depth_load.
REQ-012 Port depth_load, input, 1: single-cycle pulse that latches depth and restarts fill.
REQ-013 Port Q, output, NTAPS*DSIZE: field k (bits k*DSIZE +: DSIZE) is tap k output.
REQ-014 Port q_valid, output, 1: Q updated this cycle.
REQ-015 Port primed, output, 1: all taps hold real samples.

Function
REQ-016 Storage is NTAPS circular buffers of MAX_DEPTH x DSIZE words each, inferred as RAM, not flops.
REQ-017 Effective depth D is the latched depth, with 0 clamped to 1 and values above MAX_DEPTH clamped to MAX_DEPTH.
REQ-018 One shared write pointer wraps from D-1 to 0 and advances only on accepted samples.
REQ-019 An accept is an edge where din_valid=1, depth_load=0 and Reset=0.
REQ-020 Counting accepts as n, the edge after accept n sets field k of Q to sample n-(k+1)*D, for k=0..NTAPS-1.
REQ-021 Taps cascade: tap k+1 is fed by the output stream of tap k.
REQ-022 Latency is fixed: q_valid is registered and asserted exactly one cycle after each accept (subject to REQ-030).
REQ-023 If no accept occurred at the previous edge, q_valid=0 and Q holds its value.
REQ-024 Gaps in din_valid of any length do not change delay results; delay counts in accepts, not cycles.
REQ-025 depth_load=1 latches depth, resets the pointer to 0, clears the fill count and deasserts primed.
REQ-026 A depth_load edge accepts no sample: Din is dropped even if din_valid=1, and q_valid=0 in the next cycle.
REQ-027 Fill count increments per accept and saturates at NTAPS*D+1.
REQ-028 primed=1 once the fill count reaches NTAPS*D+1, meaning field NTAPS-1 holds a real sample.
REQ-029 Stale RAM contents from before the current depth_load are never cleared.

Reset
REQ-030 Reset=1 at an edge drives Q=0, q_valid=0, primed=0, pointer=0, fill count=0 and D=clamped DEFAULT_DEPTH.
REQ-031 Reset overrides depth_load and din_valid at the same edge, including mid-stream; RAM contents are not cleared.

Configuration
REQ-032 Macro RAM_TAP_PRIMED_EN, when defined, implements the fill counter and drives primed.
REQ-033 With RAM_TAP_PRIMED_EN, q_valid asserts only after an accept that leaves primed=1.
REQ-034 Without RAM_TAP_PRIMED_EN, the fill counter is absent, primed is tied 0, and q_valid follows every accept per REQ-022.
REQ-035 The port list is identical in both builds.

Verification
All scenarios use DSIZE=8, MAX_DEPTH=16, NTAPS=3, macro defined unless stated, and depth_load with depth=4 after reset.
REQ-036 Continuous din_valid, Din=0,1,2,...: at the edge after the accept of Din=12, q_valid=1, primed=1, Q fields {0,1,2}={8,4,0}; no q_valid before that point.
REQ-037 din_valid alternating 1/0 with the same Din sequence: the same Q values as REQ-036 appear at the same accept indices, and Q holds during gaps.
REQ-038 Mid-stream depth_load with depth=15 and din_valid=1: that Din is dropped, primed=0 on the next cycle, and the first q_valid follows the 46th subsequent accept with field0 = the sample 15 accepts earlier.
REQ-039 depth=0 loaded: behaves as D=1; after 4 accepts of 10,11,12,13, Q={12,11,10}.
REQ-040 Reset asserted for 1 cycle mid-stream: Q=0, q_valid=0 and primed=0 next cycle; refill then repeats REQ-036 with D=DEFAULT_DEPTH=16.
REQ-041 Macro undefined: q_valid=1 one cycle after the first accept; primed stays 0 throughout.
